// File: rtl/serializer_pkg.sv
// Shared constants and helpers for the parametrised handshake serializer.
// Bit-order encoding, default idle pattern generator and default counter width.
`timescale 1ns/1ps
package serializer_pkg;

  localparam logic BIT_MSB_FIRST    = 1'b0;
  localparam logic BIT_LSB_FIRST    = 1'b1;
  localparam int   DEFAULT_CNTWIDTH = 16;
  localparam int   MAX_WORDWIDTH    = 32;

  // Alternating 1010... pattern with a 1 in the MSB position of a width-bit word.
  function automatic logic [MAX_WORDWIDTH-1:0] idle_pattern(input int width);
    logic [MAX_WORDWIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < width; i++) begin
      p[i] = ((width - 1 - i) % 2) == 0;
    end
    return p;
  endfunction

endpackage

// File: rtl/serializer_shift_core.sv
// Shift register, bit counter and per-word bit order for the serializer.
// Emits one bit per enabled cycle; the owner decides what gets loaded.
`timescale 1ns/1ps
module serializer_shift_core
  import serializer_pkg::*;
#(
  parameter int WORDWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 load,
  input  logic [WORDWIDTH-1:0] load_word,
  input  logic                 order_in,
  output logic                 sout,
  output logic                 last_bit
);

  localparam int             CW   = (WORDWIDTH > 1) ? $clog2(WORDWIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WORDWIDTH - 1);

  logic [WORDWIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 order_q, order_d;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    order_d   = order_q;
    if (load) begin
      shift_d   = load_word;
      bit_cnt_d = '0;
      order_d   = order_in;
    end else if (enable) begin
      shift_d   = (order_q == BIT_LSB_FIRST) ? {1'b0, shift_q[WORDWIDTH-1:1]}
                                             : {shift_q[WORDWIDTH-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + CW'(1);
    end
  end

  // Counter resets to the last slot so the first enabled cycle after reset is a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments here so all flops update from pre-edge values.
      shift_q   <= '0;
      bit_cnt_q <= LAST;
      order_q   <= BIT_MSB_FIRST;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      order_q   <= order_d;
    end
  end

  assign sout     = (order_q == BIT_LSB_FIRST) ? shift_q[0] : shift_q[WORDWIDTH-1];
  assign last_bit = (bit_cnt_q == LAST);

endmodule

// File: rtl/serializer_hs_param.sv
// Valid/ready front end with a one-entry holding register feeding the shift core.
// Inserts IDLE_WORD when nothing is pending and counts those insertions.
`timescale 1ns/1ps
module serializer_hs_param
  import serializer_pkg::*;
#(
  parameter int                   WORDWIDTH = 8,
  parameter logic [WORDWIDTH-1:0] IDLE_WORD = WORDWIDTH'(idle_pattern(WORDWIDTH)),
  parameter int                   CNTWIDTH  = DEFAULT_CNTWIDTH
) (
  input  logic                 clk320,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 lsbFirst,
  input  logic [WORDWIDTH-1:0] din,
  input  logic                 dinValid,
  output logic                 dinReady,
  output logic                 sout,
  output logic                 wordStart,
  output logic                 wordIsIdle,
  input  logic                 clrCnt,
  output logic [CNTWIDTH-1:0]  idleCount
);

  logic                 last_bit;
  logic                 load_event;
  logic                 accept;
  logic [WORDWIDTH-1:0] load_word;

  logic [WORDWIDTH-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 word_start_q, word_start_d;
  logic                 word_is_idle_q, word_is_idle_d;
  logic [CNTWIDTH-1:0]  idle_count_q, idle_count_d;

  assign load_event = enable & last_bit;
  assign dinReady   = ~hold_full_q | load_event;
  assign accept     = dinValid & dinReady;
  // No bypass: a word accepted during a load only reaches the shifter at the next load.
  assign load_word  = hold_full_q ? hold_q : IDLE_WORD;

  always_comb begin
    hold_d         = hold_q;
    hold_full_d    = hold_full_q;
    word_start_d   = load_event;
    word_is_idle_d = word_is_idle_q;
    idle_count_d   = idle_count_q;

    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end else if (load_event) begin
      hold_full_d = 1'b0;
    end

    if (load_event) begin
      word_is_idle_d = ~hold_full_q;
    end

    if (clrCnt) begin
      idle_count_d = '0;
    end else if (load_event && !hold_full_q && (idle_count_q != '1)) begin
      idle_count_d = idle_count_q + CNTWIDTH'(1);
    end
  end

  always_ff @(posedge clk320 or negedge rstn) begin
    if (!rstn) begin
      hold_full_q    <= 1'b0;
      word_start_q   <= 1'b0;
      word_is_idle_q <= 1'b0;
      idle_count_q   <= '0;
    end else begin
      hold_full_q    <= hold_full_d;
      word_start_q   <= word_start_d;
      word_is_idle_q <= word_is_idle_d;
      idle_count_q   <= idle_count_d;
    end
  end

  // NOTE: holding data has no reset; hold_full_q qualifies it, so only the flag needs one.
  always_ff @(posedge clk320) begin
    hold_q <= hold_d;
  end

  serializer_shift_core #(
    .WORDWIDTH(WORDWIDTH)
  ) u_core (
    .clk      (clk320),
    .rst_n    (rstn),
    .enable   (enable),
    .load     (load_event),
    .load_word(load_word),
    .order_in (lsbFirst),
    .sout     (sout),
    .last_bit (last_bit)
  );

  assign wordStart  = word_start_q;
  assign wordIsIdle = word_is_idle_q;
  assign idleCount  = idle_count_q;

endmodule
